// File: rtl/fifo_uart_tx.sv
// Drains sync_fifo one byte per frame and serialises it onto a UART line, LSB first (8N1).
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | line idle high, waiting for FIFO non-empty
// S_REQ    | fifo_rd_en high for this single cycle, FIFO pops on exit edge
// S_WAIT   | FIFO read data valid, captured into shift register on exit
// S_START  | start bit (tx=0)
// S_DATA   | data bits, LSB first
// S_PARITY | even parity over the captured byte (parity build only)
// S_STOP   | stop bit (tx=1), frame_done in its last cycle
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_START, S_DATA, S_STOP
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [CW-1:0]         baud_cnt_q, baud_cnt_d;
    logic [BW-1:0]         bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_d;
    logic                  rd_en_d;
    logic                  baud_last;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    assign baud_last = (baud_cnt_q == BAUD_LAST);
    assign busy      = (state_q != S_IDLE);

    // tx resets asynchronously, so the line goes idle the moment rst_n drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx         <= tx_d;
            fifo_rd_en <= rd_en_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx;
        rd_en_d    = 1'b0;
        frame_done = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    rd_en_d = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                shift_d    = fifo_data;
                tx_d       = 1'b0;
                baud_cnt_d = '0;
                bit_idx_d  = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d   = ^fifo_data;
`endif
                state_d    = S_START;
            end
            S_START: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    tx_d       = shift_q[0];
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    shift_d    = shift_q >> 1;
                    bit_idx_d  = bit_idx_q + BW'(1);
                    if (bit_idx_q == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        tx_d = shift_d[0];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CW'(1);
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    tx_d       = 1'b1;
                    state_d    = S_STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    frame_done = 1'b1;
                    tx_d       = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + CW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: queue-based sync_fifo model, per-cycle line log and a mid-bit UART receiver model.
// Build with FIFO_UART_TX_PARITY_EN defined to also exercise the parity frame.
module tb_fifo_uart_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB  = 11;
`else
    localparam int NB  = 10;
`endif
    localparam int FL  = NB * CPB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data  = '0;
    logic          fifo_rd_en;
    logic          tx;
    logic          busy;
    logic          frame_done;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rec;

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // sync_fifo model: registered read data, empty flag updated on the clock edge
    logic [DW-1:0] fq[$];
    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() > 0) begin
            fifo_data <= fq[0];
            fq.delete(0);
        end
        if (wr_en) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
    end

    logic tx_log[$], rd_log[$], fd_log[$], busy_log[$];
    int   viol = 0;
    always @(posedge clk) begin
        #1;
        if (fifo_rd_en && fifo_empty) viol++;
        if (rec) begin
            tx_log.push_back(tx);
            rd_log.push_back(fifo_rd_en);
            fd_log.push_back(frame_done);
            busy_log.push_back(busy);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        tx_log.delete(); rd_log.delete(); fd_log.delete(); busy_log.delete();
    endtask

    task automatic push_byte(input logic [DW-1:0] b);
        wr_data = b;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((busy || !fifo_empty) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < maxc), 32'd1);
        repeat (5) @(negedge clk);
    endtask

    function automatic int ones(input logic q[$]);
        int s = 0;
        foreach (q[i]) if (q[i] === 1'b1) s++;
        return s;
    endfunction

    // Ideal line level at cycle j of a frame carrying byte b
    function automatic logic frame_bit(input logic [DW-1:0] b, input int j);
        int k = j / CPB;
        if (k == 0) return 1'b0;
        if (k <= DW) return b[k-1];
`ifdef FIFO_UART_TX_PARITY_EN
        if (k == DW + 1) return ^b;
`endif
        return 1'b1;
    endfunction

    // UART receiver model: find each falling edge, sample mid-bit
    logic [DW-1:0] rx_bytes[$];
    logic          rx_par[$];
    int            rx_starts[$];
    int            stop_bad, fd_bad;

    task automatic decode();
        int i = 0;
        rx_bytes.delete(); rx_par.delete(); rx_starts.delete();
        stop_bad = 0;
        fd_bad   = 0;
        while (i + FL <= tx_log.size()) begin
            if (tx_log[i] === 1'b0) begin
                logic [DW-1:0] b = '0;
                for (int k = 0; k < DW; k++) b[k] = tx_log[i + CPB*(k+1) + CPB/2];
                rx_bytes.push_back(b);
                rx_starts.push_back(i);
`ifdef FIFO_UART_TX_PARITY_EN
                rx_par.push_back(tx_log[i + CPB*(DW+1) + CPB/2]);
`endif
                if (tx_log[i + CPB*(NB-1) + CPB/2] !== 1'b1) stop_bad++;
                if (fd_log[i + FL - 1] !== 1'b1) fd_bad++;
                i += FL;
            end else begin
                i++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp_q[$];
        int            bad;
        int            n;

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rec     = 1'b0;
        repeat (2) @(negedge clk);

        // reset held with a non-empty FIFO
        push_byte(8'hA5);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_tx", 32'(tx), 32'd1);
            check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        clear_logs();
        rec   = 1'b1;
        rst_n = 1'b1;
        wait_idle(400);

        // single byte 0xA5, exact waveform
        check("first_rd_en", 32'(rd_log.size() > 0 ? rd_log[0] : 1'b0), 32'd1);
        bad = 0;
        for (int i = 0; i < tx_log.size(); i++) begin
            logic e;
            e = (i >= 2 && i < 2 + FL) ? frame_bit(8'hA5, i - 2) : 1'b1;
            if (tx_log[i] !== e) bad++;
        end
        check("a5_wave_errs", 32'(bad), 32'd0);
        check("a5_rd_pulses", 32'(ones(rd_log)), 32'd1);
        check("a5_fd_pulses", 32'(ones(fd_log)), 32'd1);
        check("a5_fd_pos", 32'(fd_log.size() > FL + 1 ? fd_log[FL + 1] : 1'b0), 32'd1);

        // back-to-back frames
        clear_logs();
        push_byte(8'h01);
        push_byte(8'hFF);
        push_byte(8'h80);
        wait_idle(1000);
        decode();
        check("b2b_frames", 32'(rx_bytes.size()), 32'd3);
        if (rx_bytes.size() == 3) begin
            check("b2b_byte0", 32'(rx_bytes[0]), 32'h01);
            check("b2b_byte1", 32'(rx_bytes[1]), 32'hFF);
            check("b2b_byte2", 32'(rx_bytes[2]), 32'h80);
            check("b2b_gap0", 32'(rx_starts[1] - rx_starts[0] - FL), 32'd3);
            check("b2b_gap1", 32'(rx_starts[2] - rx_starts[1] - FL), 32'd3);
        end
        check("b2b_rd_pulses", 32'(ones(rd_log)), 32'd3);
        check("b2b_fd_pulses", 32'(ones(fd_log)), 32'd3);
        check("b2b_stop_errs", 32'(stop_bad), 32'd0);
        check("b2b_fd_errs", 32'(fd_bad), 32'd0);
        check("rd_while_empty", 32'(viol), 32'd0);

        // empty FIFO
        clear_logs();
        repeat (100) @(negedge clk);
        check("empty_rd_en", 32'(ones(rd_log)), 32'd0);
        check("empty_tx_high", 32'(ones(tx_log)), 32'(tx_log.size()));
        check("empty_busy", 32'(ones(busy_log)), 32'd0);

        // reset during data bit 3 of 0x3C, then 0x55 must go out intact
        clear_logs();
        push_byte(8'h3C);
        push_byte(8'h55);
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_start_timeout", 32'(n < 200), 32'd1);
        repeat (17) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
        wait_idle(400);
        decode();
        check("mid_frames", 32'(rx_bytes.size()), 32'd1);
        if (rx_bytes.size() == 1) check("mid_byte", 32'(rx_bytes[0]), 32'h55);
        check("mid_stop_errs", 32'(stop_bad), 32'd0);

        // random bytes with random spacing
        clear_logs();
        exp_q.delete();
        for (int r = 0; r < 6; r++) begin
            logic [DW-1:0] b;
            repeat ($urandom_range(0, 60)) @(negedge clk);
            b = DW'($urandom);
            exp_q.push_back(b);
            push_byte(b);
        end
        wait_idle(3000);
        decode();
        check("rnd_frames", 32'(rx_bytes.size()), 32'(exp_q.size()));
        if (rx_bytes.size() == exp_q.size()) begin
            foreach (exp_q[i]) begin
                check("rnd_byte", 32'(rx_bytes[i]), 32'(exp_q[i]));
`ifdef FIFO_UART_TX_PARITY_EN
                check("rnd_parity", 32'(rx_par[i]), 32'(^exp_q[i]));
`endif
            end
        end
        check("rnd_rd_pulses", 32'(ones(rd_log)), 32'(exp_q.size()));
        check("rnd_stop_errs", 32'(stop_bad), 32'd0);
        check("rnd_fd_errs", 32'(fd_bad), 32'd0);
        check("rnd_rd_while_empty", 32'(viol), 32'd0);

`ifdef FIFO_UART_TX_PARITY_EN
        clear_logs();
        push_byte(8'h07);
        wait_idle(400);
        push_byte(8'h03);
        wait_idle(400);
        decode();
        check("par_frames", 32'(rx_bytes.size()), 32'd2);
        if (rx_par.size() == 2) begin
            check("par_07", 32'(rx_par[0]), 32'd1);
            check("par_03", 32'(rx_par[1]), 32'd0);
        end
        check("par_fd_errs", 32'(fd_bad), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
